// File: rtl/npc_pkg.sv
// Shared definitions for the NPC fetch front end: FSM state encoding and
// default widths, reset vector and sequential PC step.
package npc_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam int          ILEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam int          STEP_DEF      = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch bus and decode hand-off seen by pc_gen: the request/response channel
// towards IMEM and the buffered instruction towards the IDU.
interface pc_gen_if
    import npc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ILEN = ILEN_DEF
);
    logic            if_req_valid;
    logic [XLEN-1:0] if_req_addr;
    logic            if_req_ready;
    logic            if_resp_valid;
    logic [ILEN-1:0] if_resp_data;
    logic            inst_valid;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        output if_req_valid, if_req_addr, inst_valid, inst, inst_pc,
        input  if_req_ready, if_resp_valid, if_resp_data, inst_ready
    );

    modport slave (
        input  if_req_valid, if_req_addr, inst_valid, inst, inst_pc,
        output if_req_ready, if_resp_valid, if_resp_data, inst_ready
    );
endinterface

// File: rtl/pc_gen_next.sv
// Combinational next-PC select (trap > redirect > pc+STEP > hold) and target
// alignment check; the check only exists when PC_GEN_MISALIGN_CHECK_EN is defined.
module pc_gen_next
    import npc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int STEP = STEP_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect,
    output logic            target_misaligned
);

    // The increment wraps naturally at 2^XLEN, so the last word rolls over to 0.
    always_comb begin
        redirect = trap_valid || redirect_valid;
        if (trap_valid)
            next_pc = trap_target;
        else if (redirect_valid)
            next_pc = redirect_target;
        else if (advance)
            next_pc = pc + XLEN'(STEP);
        else
            next_pc = pc;
    end

`ifdef PC_GEN_MISALIGN_CHECK_EN
    assign target_misaligned = redirect && (next_pc[1:0] != 2'b00);
`else
    assign target_misaligned = 1'b0;
`endif

endmodule

// File: rtl/pc_gen.sv
// PC generator and single-outstanding instruction fetch front end for the NPC core.
// Optional misaligned-target trapping is enabled with PC_GEN_MISALIGN_CHECK_EN.
module pc_gen
    import npc_pkg::*;
#(
    parameter int            XLEN      = XLEN_DEF,
    parameter int            ILEN      = ILEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter int            STEP      = STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    pc_gen_if.master        bus,
    output logic            misalign
);

    pc_state_e       state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic            kill;
    logic [ILEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            misalign_q;
    logic            misalign_d;
    logic [XLEN-1:0] next_pc;
    logic            redirect;
    logic            target_misaligned;
    logic            advance;
    pc_state_e       resume_state;

    assign advance = (state == S_HOLD) && bus.inst_ready;

    pc_gen_next #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_next (
        .pc                (pc),
        .advance           (advance),
        .trap_valid        (trap_valid),
        .trap_target       (trap_target),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .next_pc           (next_pc),
        .redirect          (redirect),
        .target_misaligned (target_misaligned)
    );

    // A misaligned target parks the fetcher until a clean trap redirect arrives.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect) begin
            if (target_misaligned)
                misalign_d = 1'b1;
            else if (trap_valid)
                misalign_d = 1'b0;
        end
    end

    assign resume_state = (stall || misalign_d) ? S_IDLE : S_REQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_VEC;
            req_addr   <= RESET_VEC;
            kill       <= 1'b0;
            inst_q     <= '0;
            inst_pc_q  <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            pc         <= next_pc;
            misalign_q <= misalign_d;
            unique case (state)
                S_IDLE: begin
                    state    <= resume_state;
                    req_addr <= next_pc;
                end
                // A valid request must complete even when redirected; it is killed instead.
                S_REQ: begin
                    if (redirect)
                        kill <= 1'b1;
                    if (bus.if_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.if_resp_valid) begin
                        if (kill || redirect) begin
                            kill     <= 1'b0;
                            state    <= resume_state;
                            req_addr <= next_pc;
                        end else begin
                            inst_q    <= bus.if_resp_data;
                            inst_pc_q <= pc;
                            state     <= S_HOLD;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect || bus.inst_ready) begin
                        state    <= resume_state;
                        req_addr <= next_pc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.if_req_valid = (state == S_REQ);
    assign bus.if_req_addr  = req_addr;
    assign bus.inst_valid   = (state == S_HOLD);
    assign bus.inst         = inst_q;
    assign bus.inst_pc      = inst_pc_q;

`ifdef PC_GEN_MISALIGN_CHECK_EN
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule
